// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared state encoding and frame/delay constants for the delay controller
package datapath_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } trk_state_t;

   localparam logic [25:0] FRAM_MAX_NR     = 26'd4915199;
   localparam logic [25:0] FRAM_MAX_LTE    = 26'd2457599;
   localparam logic [13:0] DELAY_MAX_DW    = 14'd8191;
   localparam logic [13:0] DELAY_MAX_UP_NR = 14'd16383;

endpackage

// File: rtl/datapath_frame_tracker.sv
// rtl/datapath_frame_tracker.sv - frame counter, header classification and lock FSM
// Optional event outputs under DATAPATH_DELAY_CTRL_STAT_EN.
module datapath_frame_tracker
   import datapath_pkg::*;
#(
   parameter logic [25:0] FRAM_MAX = FRAM_MAX_NR,
   parameter int          LOCK_N   = 3,
   parameter int          UNLOCK_N = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fram_hd,
   output logic [25:0] fcnt,
   output logic        frame_start,
   output trk_state_t  state,
   output logic        hd_err
`ifdef DATAPATH_DELAY_CTRL_STAT_EN
   ,
   output logic        miss_ev,
   output logic        early_ev
`endif
);

   localparam int CW = $clog2(((LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N) + 1);
   localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_N);
   localparam logic [CW-1:0] UNLOCK_C = CW'(UNLOCK_N);

   trk_state_t    state_nxt;
   logic [CW-1:0] good, good_nxt;
   logic [CW-1:0] bad, bad_nxt;
   logic          err_nxt;
   logic          at_max, on_time, early, missing;

   assign at_max  = (fcnt == FRAM_MAX);
   assign on_time = fram_hd && at_max;
   assign early   = fram_hd && !at_max;
   assign missing = at_max && !fram_hd;

`ifdef DATAPATH_DELAY_CTRL_STAT_EN
   assign miss_ev  = missing && (state != SEARCH);
   assign early_ev = early && (state != SEARCH);
`endif

   always_comb begin
      state_nxt   = state;
      good_nxt    = good;
      bad_nxt     = bad;
      err_nxt     = 1'b0;
      frame_start = at_max;
      case (state)
         SEARCH: begin
            if (fram_hd) begin
               frame_start = 1'b1;
               good_nxt    = '0;
               state_nxt   = CHECK;
            end
         end
         CHECK: begin
            if (on_time) begin
               good_nxt = good + 1'b1;
               if (good_nxt == LOCK_C) begin
                  state_nxt = LOCKED;
                  bad_nxt   = '0;
               end
            end else if (early) begin
               frame_start = 1'b1;
               good_nxt    = '0;
               err_nxt     = 1'b1;
            end else if (missing) begin
               err_nxt   = 1'b1;
               state_nxt = SEARCH;
            end
         end
         LOCKED: begin
            // Early headers are ignored here: the flywheel keeps the established phase.
            if (on_time) begin
               bad_nxt = '0;
            end else if (early || missing) begin
               bad_nxt = bad + 1'b1;
               err_nxt = 1'b1;
            end
            if (bad_nxt == UNLOCK_C) begin
               state_nxt = SEARCH;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= SEARCH;
         fcnt   <= '0;
         good   <= '0;
         bad    <= '0;
         hd_err <= 1'b0;
      end else begin
         state  <= state_nxt;
         fcnt   <= frame_start ? 26'd0 : fcnt + 26'd1;
         good   <= good_nxt;
         bad    <= bad_nxt;
         hd_err <= err_nxt;
      end
   end

endmodule

// File: rtl/datapath_delay_ctrl.sv
// rtl/datapath_delay_ctrl.sv - frame-delay sequencer: delay registers, adjust pulse and stats
// Optional miss/early statistics counters under DATAPATH_DELAY_CTRL_STAT_EN.
module datapath_delay_ctrl
   import datapath_pkg::*;
#(
   parameter logic [25:0]        FRAM_MAX  = FRAM_MAX_NR,
   parameter int                 DELAY_W   = 14,
   parameter logic [DELAY_W-1:0] DELAY_MAX = DELAY_W'(8191),
   parameter logic [DELAY_W-1:0] DELAY_DEF = '0,
   parameter int                 LOCK_N    = 3,
   parameter int                 UNLOCK_N  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_fram_hd,
   input  logic [DELAY_W-1:0] i_delay,
   input  logic               i_delay_vld,
`ifdef DATAPATH_DELAY_CTRL_STAT_EN
   input  logic               i_stat_clr,
   output logic [15:0]        o_miss_cnt,
   output logic [15:0]        o_early_cnt,
`endif
   output logic               o_adjust_hd,
   output logic               o_lock,
   output logic               o_cfg_err,
   output logic               o_hd_err,
   output logic [25:0]        o_frm_cnt
);

   trk_state_t         state;
   logic [25:0]        fcnt;
   logic               frame_start;
   logic [DELAY_W-1:0] dly_pend, dly_act;

`ifdef DATAPATH_DELAY_CTRL_STAT_EN
   logic miss_ev, early_ev;
`endif

   datapath_frame_tracker #(
      .FRAM_MAX (FRAM_MAX),
      .LOCK_N   (LOCK_N),
      .UNLOCK_N (UNLOCK_N)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .fram_hd     (i_fram_hd),
      .fcnt        (fcnt),
      .frame_start (frame_start),
      .state       (state),
      .hd_err      (o_hd_err)
`ifdef DATAPATH_DELAY_CTRL_STAT_EN
      ,
      .miss_ev     (miss_ev),
      .early_ev    (early_ev)
`endif
   );

   assign o_lock    = (state == LOCKED);
   assign o_frm_cnt = fcnt;

   // dly_act samples the pre-edge dly_pend, so a capture on a frame start lands one frame later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_pend    <= DELAY_DEF;
         dly_act     <= DELAY_DEF;
         o_cfg_err   <= 1'b0;
         o_adjust_hd <= 1'b0;
      end else begin
         if (i_delay_vld) begin
            if (i_delay > DELAY_MAX) begin
               dly_pend  <= DELAY_MAX;
               o_cfg_err <= 1'b1;
            end else begin
               dly_pend  <= i_delay;
               o_cfg_err <= 1'b0;
            end
         end
         if (frame_start) begin
            dly_act <= dly_pend;
         end
         o_adjust_hd <= (state != SEARCH) && (fcnt == 26'(dly_act));
      end
   end

`ifdef DATAPATH_DELAY_CTRL_STAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_miss_cnt  <= '0;
         o_early_cnt <= '0;
      end else if (i_stat_clr) begin
         o_miss_cnt  <= '0;
         o_early_cnt <= '0;
      end else begin
         if (miss_ev && (o_miss_cnt != 16'hFFFF)) begin
            o_miss_cnt <= o_miss_cnt + 16'd1;
         end
         if (early_ev && (o_early_cnt != 16'hFFFF)) begin
            o_early_cnt <= o_early_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
